instruction_encoder: RTL and testbench

//  Inverse of the control decoder: turns a decoded instruction (kind + register/immediate fields) into a 32-bit MIPS machine word.

---
 rtl/instruction_encoder.sv | 164 ++++++++++++++++
 tb/tb_instruction_encoder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
// Instruction encoder: packs decoded MIPS instruction fields into 32-bit words and
// streams them to program memory through a two-stage registered pipeline.
module instruction_encoder #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [3:0]            InKind,
  input  logic [4:0]            Rs,
  input  logic [4:0]            Rt,
  input  logic [4:0]            Rd,
  input  logic [4:0]            Shamt,
  input  logic [5:0]            Funct,
  input  logic [15:0]           Imm,
  input  logic [25:0]           Target,
  output logic                  MemWrite,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [31:0]           MemData,
  output logic [ADDR_WIDTH:0]   Count,
  output logic                  Full,
  output logic                  Error
);

  typedef enum logic [3:0] {
    K_RGEN = 4'd0,  K_SLL  = 4'd1,  K_SRL = 4'd2,  K_JR  = 4'd3,
    K_ADDI = 4'd4,  K_ORI  = 4'd5,  K_LUI = 4'd6,  K_LW  = 4'd7,
    K_SW   = 4'd8,  K_J    = 4'd9,  K_JAL = 4'd10, K_BEQ = 4'd11,
    K_BNE  = 4'd12
  } kind_e;

  localparam logic [ADDR_WIDTH-1:0] BASE_C  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

  function automatic logic kind_legal(input logic [3:0] kind);
    return (kind <= 4'd12);
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Unused fields are forced to zero so garbage on idle inputs never leaks into the word.
  function automatic logic [31:0] encode(input logic [3:0] kind, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sh, input logic [5:0] fn,
                                         input logic [15:0] imm, input logic [25:0] tgt);
    logic [31:0] w;
    case (kind)
      K_RGEN:  w = {6'h00, rs, rt, rd, 5'd0, fn};
      K_SLL:   w = {6'h00, 5'd0, rt, rd, sh, 6'h00};
      K_SRL:   w = {6'h00, 5'd0, rt, rd, sh, 6'h02};
      K_JR:    w = {6'h00, rs, 5'd0, 5'd0, 5'd0, 6'h08};
      K_ADDI:  w = i_word(6'h08, rs, rt, imm);
      K_ORI:   w = i_word(6'h0d, rs, rt, imm);
      K_LUI:   w = i_word(6'h0f, 5'd0, rt, imm);
      K_LW:    w = i_word(6'h23, rs, rt, imm);
      K_SW:    w = i_word(6'h2b, rs, rt, imm);
      K_J:     w = {6'h02, tgt};
      K_JAL:   w = {6'h03, tgt};
      K_BEQ:   w = i_word(6'h04, rs, rt, imm);
      K_BNE:   w = i_word(6'h05, rs, rt, imm);
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  logic                  s1_valid_q, s1_valid_d;
  logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
  logic [31:0]           s1_word_q, s1_word_d;
  logic [ADDR_WIDTH-1:0] wr_idx_q, wr_idx_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  error_q, error_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_data_q, mem_data_d;
  logic                  ready_s;
  logic                  accept_s;

  assign ready_s  = !Start && (count_q < DEPTH_C);
  assign accept_s = InValid && ready_s;

  // Next-state logic: Start wins over everything and flushes both stages.
  always_comb begin
    s1_valid_d  = 1'b0;
    s1_addr_d   = s1_addr_q;
    s1_word_d   = s1_word_q;
    wr_idx_d    = wr_idx_q;
    count_d     = count_q;
    error_d     = error_q;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    if (Start) begin
      wr_idx_d   = '0;
      count_d    = '0;
      error_d    = 1'b0;
      mem_addr_d = BASE_C;
      mem_data_d = 32'h0000_0000;
    end else begin
      mem_write_d = s1_valid_q;
      if (s1_valid_q) begin
        mem_addr_d = s1_addr_q;
        mem_data_d = s1_word_q;
      end else begin
        mem_addr_d = mem_addr_q;
      end
      if (accept_s && kind_legal(InKind)) begin
        s1_valid_d = 1'b1;
        s1_addr_d  = BASE_C + wr_idx_q;
        s1_word_d  = encode(InKind, Rs, Rt, Rd, Shamt, Funct, Imm, Target);
        wr_idx_d   = wr_idx_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        count_d    = count_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
      end else if (accept_s) begin
        error_d = 1'b1;
      end else begin
        s1_valid_d = 1'b0;
      end
    end
    full_d = (count_d == DEPTH_C);
  end

  // State registers; async reset drops anything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= BASE_C;
      s1_word_q   <= 32'h0000_0000;
      wr_idx_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      error_q     <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= BASE_C;
      mem_data_q  <= 32'h0000_0000;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_addr_q   <= s1_addr_d;
      s1_word_q   <= s1_word_d;
      wr_idx_q    <= wr_idx_d;
      count_q     <= count_d;
      full_q      <= full_d;
      error_q     <= error_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
    end
  end

  assign InReady  = ready_s;
  assign MemWrite = mem_write_q;
  assign MemAddr  = mem_addr_q;
  assign MemData  = mem_data_q;
  assign Count    = count_q;
  assign Full     = full_q;
  assign Error    = error_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: directed cases then random traffic,
// compared cycle by cycle against a queue-based write scoreboard.
module tb_instruction_encoder;

  localparam int          DEPTH = 4;
  localparam logic [7:0]  BASE  = 8'hFE;
  localparam int          OPC [13] = '{0, 0, 0, 0, 8, 13, 15, 35, 43, 2, 3, 4, 5};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [3:0]  InKind = 4'd0;
  logic [4:0]  Rs = 5'd0, Rt = 5'd0, Rd = 5'd0, Shamt = 5'd0;
  logic [5:0]  Funct = 6'd0;
  logic [15:0] Imm = 16'd0;
  logic [25:0] Target = 26'd0;
  logic        MemWrite;
  logic [7:0]  MemAddr;
  logic [31:0] MemData;
  logic [8:0]  Count;
  logic        Full;
  logic        Error;

  instruction_encoder #(.ADDR_WIDTH(8), .BASE_ADDR(254), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .reset(reset), .Start(Start), .InValid(InValid), .InReady(InReady),
    .InKind(InKind), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Shamt(Shamt), .Funct(Funct),
    .Imm(Imm), .Target(Target), .MemWrite(MemWrite), .MemAddr(MemAddr),
    .MemData(MemData), .Count(Count), .Full(Full), .Error(Error)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [7:0] addr; logic [31:0] word; } wr_t;
  wr_t q[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;
  int  m_count = 0;
  int  m_idx = 0;
  bit  m_err = 1'b0;

  // Word built from field positions with plain arithmetic.
  function automatic logic [31:0] ref_word(int k, int rs, int rt, int rd, int sh,
                                           int fn, int imm, int tgt);
    longint w;
    if (k == 0)      w = rs * 2097152 + rt * 65536 + rd * 2048 + fn;
    else if (k == 1) w = rt * 65536 + rd * 2048 + sh * 64;
    else if (k == 2) w = rt * 65536 + rd * 2048 + sh * 64 + 2;
    else if (k == 3) w = rs * 2097152 + 8;
    else if (k == 9 || k == 10) w = longint'(OPC[k]) * 67108864 + tgt;
    else w = longint'(OPC[k]) * 67108864 + (k == 6 ? 0 : rs) * 2097152 + rt * 65536 + imm;
    return w[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic s);
    logic [7:0] a;
    InValid = v;
    Start   = s;
    #1;
    chk("in_ready", {31'd0, InReady}, {31'd0, (!s && m_count < DEPTH)});
    @(posedge clk);
    cyc++;
    if (s) begin
      m_count = 0; m_idx = 0; m_err = 1'b0;
      while (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
    end else if (v && m_count < DEPTH) begin
      if (InKind <= 4'd12) begin
        a = BASE + 8'(m_idx);
        q.push_back('{cyc + 1, a, ref_word(int'(InKind), int'(Rs), int'(Rt), int'(Rd),
                      int'(Shamt), int'(Funct), int'(Imm), int'(Target))});
        m_count++; m_idx++;
      end else begin
        m_err = 1'b1;
      end
    end
    @(negedge clk);
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("mem_write", {31'd0, MemWrite}, 32'd1);
      chk("mem_addr", {24'd0, MemAddr}, {24'd0, q[0].addr});
      chk("mem_data", MemData, q[0].word);
      void'(q.pop_front());
    end else begin
      chk("mem_write_idle", {31'd0, MemWrite}, 32'd0);
    end
    chk("count", {23'd0, Count}, 32'(m_count));
    chk("full", {31'd0, Full}, {31'd0, (m_count == DEPTH)});
    chk("error", {31'd0, Error}, {31'd0, m_err});
  endtask

  task automatic do_reset();
    reset = 1'b1; InValid = 1'b0; Start = 1'b0;
    #1;
    chk("rst_mem_write", {31'd0, MemWrite}, 32'd0);
    chk("rst_mem_addr", {24'd0, MemAddr}, {24'd0, BASE});
    chk("rst_mem_data", MemData, 32'd0);
    chk("rst_count", {23'd0, Count}, 32'd0);
    chk("rst_full_err", {30'd0, Full, Error}, 32'd0);
    chk("rst_ready", {31'd0, InReady}, 32'd1);
    q.delete(); m_count = 0; m_idx = 0; m_err = 1'b0;
    @(posedge clk); cyc++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_addi(input logic [4:0] rt, input logic [15:0] imm);
    InKind = 4'd4; Rs = 5'd0; Rt = rt; Imm = imm;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    set_addi(5'd8, 16'd5);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("addi_word", MemData, 32'h2008_0005);
    chk("addi_addr", {24'd0, MemAddr}, {24'd0, BASE});
    step(1'b0, 1'b1);

    InKind = 4'd1; Rd = 5'd9; Rt = 5'd8; Shamt = 5'd2; Rs = 5'd31;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("sll_word", MemData, 32'h0008_4880);
    step(1'b0, 1'b1);

    InKind = 4'd10; Target = 26'h010_0008;
    step(1'b1, 1'b0);
    InKind = 4'd7; Rt = 5'd10; Rs = 5'd29; Imm = 16'hFFFC;
    step(1'b1, 1'b0);
    chk("jal_word", MemData, 32'h0C10_0008);
    step(1'b0, 1'b0);
    chk("lw_word", MemData, 32'h8FAA_FFFC);
    chk("lw_addr", {24'd0, MemAddr}, 32'h0000_00FF);
    step(1'b0, 1'b1);

    for (int i = 0; i < 6; i++) begin
      InKind = 4'd5; Rs = 5'(i); Rt = 5'(i + 3); Imm = 16'(16'h1111 * i);
      step(1'b1, 1'b0);
    end
    chk("full_flag", {31'd0, Full}, 32'd1);
    chk("full_ready", {31'd0, InReady}, 32'd0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("start_count", {23'd0, Count}, 32'd0);
    set_addi(5'd3, 16'h0042);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("restart_addr", {24'd0, MemAddr}, {24'd0, BASE});
    step(1'b0, 1'b1);

    InKind = 4'd14;
    step(1'b1, 1'b0);
    chk("illegal_err", {31'd0, Error}, 32'd1);
    step(1'b0, 1'b0);
    set_addi(5'd4, 16'h0007);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("illegal_addr", {24'd0, MemAddr}, {24'd0, BASE});
    step(1'b0, 1'b1);
    chk("err_clear", {31'd0, Error}, 32'd0);

    set_addi(5'd5, 16'h1234);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    chk("flush_write", {31'd0, MemWrite}, 32'd0);
    chk("flush_addr", {24'd0, MemAddr}, {24'd0, BASE});

    step(1'b1, 1'b0);
    do_reset();
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    do_reset();

    for (int i = 0; i < 400; i++) begin
      InKind = 4'($urandom_range(0, 15));
      Rs = 5'($urandom); Rt = 5'($urandom); Rd = 5'($urandom); Shamt = 5'($urandom);
      Funct = 6'($urandom); Imm = 16'($urandom); Target = 26'($urandom);
      step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 11) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
